fifo_consumer: RTL and testbench



---
 rtl/fifo_consumer.sv | 146 ++++++++++++++
 tb/tb_fifo_consumer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_consumer.sv
// fifo_consumer: read-side client of a single-clock FIFO.
// Pulls one word at a time through read/empty/fifo_dout, presents it on a
// valid/ready handshake downstream, keeps a running word count and modular
// sum of delivered words, and inserts GAP idle cycles after every transfer.
//
// Handshake: a downstream transfer happens at a rising edge where
// data_valid && data_ready are both high; data_valid never drops and
// data_out never changes while a word is waiting, and data_ready seen while
// data_valid is low has no effect.
module fifo_consumer #(
    parameter int K   = 8,
    parameter int GAP = 2,
    parameter int CW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            empty,
    input  logic [K-1:0]    fifo_dout,
    output logic            read,
    output logic [K-1:0]    data_out,
    output logic            data_valid,
    input  logic            data_ready,
    output logic [CW-1:0]   count,
    output logic [K+CW-1:0] sum,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    // State encoding kept as plain constants so older tools and checkers
    // can compare against fixed codes.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    // Gap counter only needs to hold GAP-1; keep at least one bit so the
    // GAP==0 build still has a legal (unused) register.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    logic [2:0]      state_q, state_d;
    logic [K-1:0]    data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic [K+CW-1:0] sum_q, sum_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            xfer;

    // A word leaves only from HOLD, where data_valid is guaranteed high.
    assign xfer = data_valid_q && data_ready;

    // Next-state and datapath decisions for the read/hold/throttle sequence.
    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        count_d      = count_q;
        sum_d        = sum_q;
        gap_d        = gap_q;

        case (state_q)
            S_IDLE: begin
                // enable is only consulted here, so dropping it mid-word
                // lets the in-flight word finish.
                if (enable && !empty) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Single-cycle read strobe; we are the only reader, so
                // empty cannot rise between the IDLE decision and here.
                state_d = S_LOAD;
            end

            S_LOAD: begin
                // FIFO output register now holds the requested word.
                data_out_d   = fifo_dout;
                data_valid_d = 1'b1;
                state_d      = S_HOLD;
            end

            S_HOLD: begin
                if (xfer) begin
                    data_valid_d = 1'b0;
                    count_d      = count_q + 1'b1;
                    sum_d        = sum_q + {{CW{1'b0}}, data_out_q};
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                // Counter starts at GAP-1, so exactly GAP cycles are
                // spent here before returning to IDLE.
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d      = S_IDLE;
                data_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            count_q      <= '0;
            sum_q        <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            gap_q        <= gap_d;
        end
    end

    // Read is gated by rst so the FIFO never sees a strobe while both
    // blocks are being reset, even if we were in REQ at the time.
    assign read       = (state_q == S_REQ) && rst;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign count      = count_q;
    assign sum        = sum_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_consumer.sv
// tb_fifo_consumer: directed bench for fifo_consumer with a behavioural
// FIFO model, an expected-word queue per instance and a negedge monitor.
// Instance a is built with GAP=2, instance b with GAP=0.
module tb_fifo_consumer;
    localparam int K  = 8;
    localparam int CW = 16;
    localparam logic [2:0] S_IDLE = 3'd0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic enable_a = 1'b0, enable_b = 1'b0;
    logic data_ready = 1'b0;

    logic            empty_a = 1'b1, empty_b = 1'b1;
    logic [K-1:0]    fifo_dout_a = '0, fifo_dout_b = '0;
    logic            read_a, read_b;
    logic [K-1:0]    data_out_a, data_out_b;
    logic            data_valid_a, data_valid_b;
    logic [CW-1:0]   count_a, count_b;
    logic [K+CW-1:0] sum_a, sum_b;
    logic            busy_a, busy_b;
    logic [2:0]      dbg_state_a, dbg_state_b;

    fifo_consumer #(.K(K), .GAP(2), .CW(CW)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .empty(empty_a),
        .fifo_dout(fifo_dout_a), .read(read_a), .data_out(data_out_a),
        .data_valid(data_valid_a), .data_ready(data_ready), .count(count_a),
        .sum(sum_a), .busy(busy_a), .dbg_state(dbg_state_a)
    );

    fifo_consumer #(.K(K), .GAP(0), .CW(CW)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .empty(empty_b),
        .fifo_dout(fifo_dout_b), .read(read_b), .data_out(data_out_b),
        .data_valid(data_valid_b), .data_ready(data_ready), .count(count_b),
        .sum(sum_b), .busy(busy_b), .dbg_state(dbg_state_b)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int mon_checks = 0;
    int mon_errors = 0;
    int cyc = 0;

    logic [K-1:0] fq_a[$];
    logic [K-1:0] fq_b[$];
    logic [K-1:0] exp_qa[$];
    logic [K-1:0] exp_qb[$];
    int rd_a[$];
    int rd_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: models the FIFO registered read port, then steps to #1
    // after the edge where inputs are changed and directed checks run.
    task automatic tick();
        logic ra, rb;
        ra = read_a;
        rb = read_b;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            fq_a.delete();
            fq_b.delete();
        end else begin
            if (ra) begin
                rd_a.push_back(cyc);
                if (fq_a.size() == 0) chk("underflow_a", 1, 0);
                else fifo_dout_a = fq_a.pop_front();
            end
            if (rb) begin
                rd_b.push_back(cyc);
                if (fq_b.size() == 0) chk("underflow_b", 1, 0);
                else fifo_dout_b = fq_b.pop_front();
            end
        end
        empty_a = (fq_a.size() == 0);
        empty_b = (fq_b.size() == 0);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_a(input logic [K-1:0] v);
        fq_a.push_back(v);
        exp_qa.push_back(v);
        empty_a = 1'b0;
    endtask

    task automatic load_a(input logic [K-1:0] v);  // stays in FIFO or is dropped
        fq_a.push_back(v);
        empty_a = 1'b0;
    endtask

    task automatic push_b(input logic [K-1:0] v);
        fq_b.push_back(v);
        exp_qb.push_back(v);
        empty_b = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while ((exp_qa.size() != 0 || busy_a) && n < budget) begin
            tick();
            n++;
        end
        chk("timeout_done_a", (n >= budget), 0);
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while ((exp_qb.size() != 0 || busy_b) && n < budget) begin
            tick();
            n++;
        end
        chk("timeout_done_b", (n >= budget), 0);
    endtask

    task automatic wait_valid_a(input int budget);
        int n = 0;
        while (!data_valid_a && n < budget) begin
            tick();
            n++;
        end
        chk("timeout_valid_a", (n >= budget), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && data_valid_a && data_ready) begin
            mon_checks++;
            if (exp_qa.size() == 0) begin
                mon_errors++;
                $display("FAIL xfer_a unexpected word actual=%0h required=none", data_out_a);
            end else begin
                logic [K-1:0] e;
                e = exp_qa.pop_front();
                if (data_out_a !== e) begin
                    mon_errors++;
                    $display("FAIL xfer_a actual=%0h required=%0h", data_out_a, e);
                end
            end
        end
        if (rst && data_valid_b && data_ready) begin
            mon_checks++;
            if (exp_qb.size() == 0) begin
                mon_errors++;
                $display("FAIL xfer_b unexpected word actual=%0h required=none", data_out_b);
            end else begin
                logic [K-1:0] e;
                e = exp_qb.pop_front();
                if (data_out_b !== e) begin
                    mon_errors++;
                    $display("FAIL xfer_b actual=%0h required=%0h", data_out_b, e);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset with words pre-loaded, enable and ready already high
        load_a(8'h11);
        load_a(8'h22);
        enable_a = 1'b1;
        data_ready = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_read", read_a, 0);
            chk("rst_valid", data_valid_a, 0);
            chk("rst_count", count_a, 0);
            chk("rst_sum", sum_a, 0);
            chk("rst_busy", busy_a, 0);
        end
        rst = 1'b1;
        chk("rst_fifo_cleared", empty_a, 1);

        // 2: three words, GAP=2, ready held high
        rd_a.delete();
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        wait_done_a(100);
        chk("seq_reads", rd_a.size(), 3);
        chk("seq_space01", rd_a[1] - rd_a[0], 6);
        chk("seq_space12", rd_a[2] - rd_a[1], 6);
        chk("seq_count", count_a, 3);
        chk("seq_sum", sum_a, 24'h66);
        chk("seq_empty", empty_a, 1);
        chk("seq_idle", dbg_state_a, S_IDLE);

        // 3: back-pressure for 10 cycles on a single word
        do_reset();
        rd_a.delete();
        data_ready = 1'b0;
        push_a(8'hA5);
        wait_valid_a(20);
        repeat (10) begin
            chk("bp_valid", data_valid_a, 1);
            chk("bp_data", data_out_a, 8'hA5);
            chk("bp_count", count_a, 0);
            tick();
        end
        data_ready = 1'b1;
        wait_done_a(40);
        chk("bp_final_count", count_a, 1);
        chk("bp_final_sum", sum_a, 24'hA5);
        chk("bp_reads", rd_a.size(), 1);

        // 4: empty FIFO with enable high
        do_reset();
        rd_a.delete();
        repeat (20) begin
            tick();
            chk("empty_read", read_a, 0);
            chk("empty_busy", busy_a, 0);
        end
        chk("empty_idle", dbg_state_a, S_IDLE);
        chk("empty_reads", rd_a.size(), 0);

        // 5: enable dropped the cycle after the read pulse, two words queued
        do_reset();
        begin
            int n = 0;
            push_a(8'h3C);
            load_a(8'h4D);
            while (!read_a && n < 20) begin
                tick();
                n++;
            end
            chk("timeout_read_a", (n >= 20), 0);
        end
        tick();
        enable_a = 1'b0;
        wait_done_a(40);
        repeat (10) tick();
        chk("en_drop_empty", empty_a, 0);
        chk("en_drop_left", fq_a.size(), 1);
        chk("en_drop_busy", busy_a, 0);
        chk("en_drop_count", count_a, 1);
        chk("en_drop_sum", sum_a, 24'h3C);

        // 6: GAP=0 instance, four 0xFF words
        rd_b.delete();
        enable_b = 1'b1;
        data_ready = 1'b1;
        repeat (4) push_b(8'hFF);
        wait_done_b(100);
        chk("gap0_reads", rd_b.size(), 4);
        chk("gap0_space01", rd_b[1] - rd_b[0], 4);
        chk("gap0_space12", rd_b[2] - rd_b[1], 4);
        chk("gap0_space23", rd_b[3] - rd_b[2], 4);
        chk("gap0_count", count_b, 4);
        chk("gap0_sum", sum_b, 24'h3FC);
        enable_b = 1'b0;

        // 7: reset while holding 0x5A, after one delivered word
        do_reset();
        enable_a = 1'b1;
        push_a(8'h21);
        wait_done_a(40);
        chk("pre_hold_count", count_a, 1);
        data_ready = 1'b0;
        load_a(8'h5A);
        wait_valid_a(20);
        chk("hold_data", data_out_a, 8'h5A);
        rst = 1'b0;
        tick();
        chk("hrst_valid", data_valid_a, 0);
        chk("hrst_count", count_a, 0);
        chk("hrst_sum", sum_a, 0);
        chk("hrst_busy", busy_a, 0);
        chk("hrst_state", dbg_state_a, S_IDLE);
        chk("hrst_read", read_a, 0);
        rst = 1'b1;
        enable_a = 1'b0;
        repeat (3) tick();
        chk("post_rst_valid", data_valid_a, 0);
        chk("post_rst_count", count_a, 0);

        // final scoreboard drain
        chk("exp_qa_drained", exp_qa.size(), 0);
        chk("exp_qb_drained", exp_qb.size(), 0);

        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
